// File: rtl/cpu_pkg.sv
// cpu_pkg: encodings shared by the mini-CPU controller, memory bank and execute stage.
package cpu_pkg;

    localparam int CPU_WIDTH = 16;

    // Controller state presented to the datapath on stateCPU
    localparam logic [2:0] ST_OFF    = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_READ   = 3'd3;
    localparam logic [2:0] ST_CALC   = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;
    localparam logic [2:0] ST_STORE  = 3'd6;
    localparam logic [2:0] ST_SHOW   = 3'd7;

    // Instruction opcodes
    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

endpackage

// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative shift-add multiplier used by the execute stage.
// The accumulator is kept at double width so the full unsigned product is
// available; the signed upper half is recovered with two corrections, which
// is what the signed overflow flag needs.
module shift_add_mul #(
    parameter int WIDTH = 16,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic             product_ovf
);

    localparam int CW = $clog2(ITERS + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accNext;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   aReg;
    logic [WIDTH-1:0]   bReg;
    logic [WIDTH-1:0]   corrA;
    logic [WIDTH-1:0]   corrB;
    logic [WIDTH-1:0]   hiSigned;
    logic [CW-1:0]      cnt;

    // Next accumulator value and the signed upper half of the product
    always_comb begin
        accNext  = acc + (mplier[0] ? mcand : '0);
        corrA    = aReg[WIDTH-1] ? bReg : '0;
        corrB    = bReg[WIDTH-1] ? aReg : '0;
        hiSigned = accNext[2*WIDTH-1:WIDTH] - corrA - corrB;
    end

    assign done        = busy && (cnt == CW'(ITERS - 1));
    assign product_lo  = accNext[WIDTH-1:0];
    assign product_ovf = (hiSigned != {WIDTH{accNext[WIDTH-1]}});

    // Load operands on start, then one add-and-shift step per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            aReg   <= '0;
            bReg   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            aReg   <= a;
            bReg   <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= accNext;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_unit.sv
// calc_unit: execute stage of the mini-CPU. Single-cycle ALU for most opcodes,
// iterative multiplier for MUL, result and flags held until the next FETCH.
module calc_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH     = CPU_WIDTH,
    parameter int MUL_ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       stateCPU,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] v1RAM,
    input  logic [WIDTH-1:0] v2RAM,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] valorGuardarRAM,
    output logic             calcDone,
    output logic             overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] aluResult;
    logic             aluOvf;
    logic             mulStart;
    logic             mulBusy;
    logic             mulDone;
    logic [WIDTH-1:0] mulLo;
    logic             mulOvf;

    assign mulStart = (state == IDLE) && (stateCPU == ST_CALC) && (opcode == OP_MUL);

    shift_add_mul #(
        .WIDTH (WIDTH),
        .ITERS (MUL_ITERS)
    ) u_mul (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (mulStart),
        .a           (v1RAM),
        .b           (imm),
        .busy        (mulBusy),
        .done        (mulDone),
        .product_lo  (mulLo),
        .product_ovf (mulOvf)
    );

    // Single-cycle result and signed overflow for every opcode except MUL
    always_comb begin
        aluResult = '0;
        aluOvf    = 1'b0;
        case (opcode)
            OP_LOAD: aluResult = imm;
            OP_ADD: begin
                aluResult = v1RAM + v2RAM;
                aluOvf    = (v1RAM[WIDTH-1] == v2RAM[WIDTH-1]) && (aluResult[WIDTH-1] != v1RAM[WIDTH-1]);
            end
            OP_ADDI: begin
                aluResult = v1RAM + imm;
                aluOvf    = (v1RAM[WIDTH-1] == imm[WIDTH-1]) && (aluResult[WIDTH-1] != v1RAM[WIDTH-1]);
            end
            OP_SUB: begin
                aluResult = v1RAM - v2RAM;
                aluOvf    = (v1RAM[WIDTH-1] != v2RAM[WIDTH-1]) && (aluResult[WIDTH-1] != v1RAM[WIDTH-1]);
            end
            OP_SUBI: begin
                aluResult = v1RAM - imm;
                aluOvf    = (v1RAM[WIDTH-1] != imm[WIDTH-1]) && (aluResult[WIDTH-1] != v1RAM[WIDTH-1]);
            end
            OP_CLEAR:   aluResult = '0;
            OP_DISPLAY: aluResult = v1RAM;
            default:    aluResult = '0;
        endcase
    end

    // Execute FSM: capture on the first CALC, hold the result until FETCH, OFF aborts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            valorGuardarRAM <= '0;
            calcDone        <= 1'b0;
            overflow        <= 1'b0;
        end else if (stateCPU == ST_OFF) begin
            state    <= IDLE;
            calcDone <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (stateCPU == ST_CALC) begin
                        if (opcode == OP_MUL) begin
                            state <= MULT;
                        end else begin
                            valorGuardarRAM <= aluResult;
                            overflow        <= aluOvf;
                            calcDone        <= 1'b1;
                            state           <= DONE;
                        end
                    end
                end
                MULT: begin
                    if (stateCPU == ST_FETCH) begin
                        state <= IDLE;
                    end else if (mulDone) begin
                        valorGuardarRAM <= mulLo;
                        overflow        <= mulOvf;
                        calcDone        <= 1'b1;
                        state           <= DONE;
                    end else if (!mulBusy) begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (stateCPU == ST_FETCH) begin
                        calcDone <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_unit.sv
// tb_calc_unit: directed and randomized checks of calc_unit against an
// arithmetic reference model of the execute stage.
module tb_calc_unit;
    import cpu_pkg::*;

    localparam int W     = 16;
    localparam int ITERS = W;
    localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (W - 1));

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   stateCPU;
    logic [2:0]   opcode;
    logic [W-1:0] v1RAM;
    logic [W-1:0] v2RAM;
    logic [W-1:0] imm;
    logic [W-1:0] valorGuardarRAM;
    logic         calcDone;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit           mActive;
    int           mRemain;
    bit           mDone;
    bit           mOvf;
    logic [W-1:0] mVal;
    logic [W-1:0] mPendVal;
    bit           mPendOvf;

    calc_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stateCPU        (stateCPU),
        .opcode          (opcode),
        .v1RAM           (v1RAM),
        .v2RAM           (v2RAM),
        .imm             (imm),
        .valorGuardarRAM (valorGuardarRAM),
        .calcDone        (calcDone),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    // result and overflow of one instruction, computed with signed integers
    function automatic void computeRef(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [W-1:0] i,
                                       output logic [W-1:0] r, output bit ovf);
        longint sa;
        longint sb;
        longint si;
        longint full;
        logic [63:0] bits;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        si = longint'($signed(i));
        case (op)
            OP_LOAD: full = si;
            OP_ADD:  full = sa + sb;
            OP_ADDI: full = sa + si;
            OP_SUB:  full = sa - sb;
            OP_SUBI: full = sa - si;
            OP_MUL:  full = sa * si;
            OP_CLEAR: full = 0;
            default: full = sa;
        endcase
        bits = full;
        r    = bits[W-1:0];
        ovf  = (op inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL}) && (full > SMAX || full < SMIN);
    endfunction

    // model: MUL finishes ITERS edges after its CALC edge, others on the CALC edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mActive = 0; mRemain = 0; mDone = 0; mOvf = 0; mVal = '0;
        end else if (stateCPU == ST_OFF) begin
            mActive = 0; mDone = 0; mOvf = 0;
        end else if (mActive) begin
            if (stateCPU == ST_FETCH) begin
                mActive = 0;
            end else begin
                mRemain--;
                if (mRemain == 0) begin
                    mActive = 0; mDone = 1; mVal = mPendVal; mOvf = mPendOvf;
                end
            end
        end else if (mDone) begin
            if (stateCPU == ST_FETCH) mDone = 0;
        end else if (stateCPU == ST_CALC) begin
            computeRef(opcode, v1RAM, v2RAM, imm, mPendVal, mPendOvf);
            if (opcode == OP_MUL) begin
                mActive = 1; mRemain = ITERS;
            end else begin
                mDone = 1; mVal = mPendVal; mOvf = mPendOvf;
            end
        end
    end

    // per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        checks++;
        if (calcDone !== mDone || valorGuardarRAM !== mVal || (mDone && overflow !== mOvf)) begin
            errors++;
            $display("[TB] FAIL cycle_compare t=%0t: dut valor=%h done=%b ovf=%b, model valor=%h done=%b ovf=%b",
                     $time, valorGuardarRAM, calcDone, overflow, mVal, mDone, mOvf);
        end
    end

    // watchdog
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: pick = 16'h7FFF;
            1: pick = 16'h8000;
            2: pick = 16'hFFFF;
            3: pick = 16'h0001;
            default: pick = W'($urandom);
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] st, input logic [2:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] i);
        stateCPU = st; opcode = op; v1RAM = a; v2RAM = b; imm = i;
        @(posedge clk);
        #1;
    endtask

    task automatic applyNoise(input logic [2:0] st);
        applyStimulus(st, 3'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] expVal,
                               input bit expDone, input bit expOvf);
        checks++;
        if (valorGuardarRAM !== expVal || calcDone !== expDone || mVal !== expVal || mDone !== expDone ||
            (expDone && (overflow !== expOvf || mOvf !== expOvf))) begin
            errors++;
            $display("[TB] FAIL %s: dut valor=%h done=%b ovf=%b model valor=%h done=%b ovf=%b, expected valor=%h done=%b ovf=%b",
                     name, valorGuardarRAM, calcDone, overflow, mVal, mDone, mOvf, expVal, expDone, expOvf);
        end
    endtask

    task automatic checkLatency(input string name, input int got, input int expEdges);
        checks++;
        if (got != expEdges) begin
            errors++;
            $display("[TB] FAIL %s: calcDone after %0d edges, expected %0d", name, got, expEdges);
        end
    endtask

    // FETCH/DECODE/READ, one CALC edge, then WAIT (with changing inputs) until calcDone
    task automatic runOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] i, output int lat);
        applyNoise(ST_FETCH);
        applyNoise(ST_DECODE);
        applyNoise(ST_READ);
        applyStimulus(ST_CALC, op, a, b, i);
        lat = 1;
        while (!calcDone && lat < 40) begin
            applyNoise(ST_WAIT);
            lat++;
        end
        if (!calcDone) begin
            checks++;
            errors++;
            $display("[TB] FAIL op_timeout: calcDone=%b after %0d edges, expected 1", calcDone, lat);
        end
    endtask

    initial begin
        int lat;
        logic [2:0] op;

        rst_n = 1'b0;
        stateCPU = ST_OFF; opcode = OP_LOAD; v1RAM = '0; v2RAM = '0; imm = '0;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("reset", 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyNoise(ST_SHOW);

        runOp(OP_ADD, 16'h0005, 16'h0003, 16'h1111, lat);
        checkLatency("add_latency", lat, 1);
        checkOutput("add", 16'h0008, 1'b1, 1'b0);

        runOp(OP_ADDI, 16'h7FFF, 16'h4444, 16'h0001, lat);
        checkOutput("addi_ovf", 16'h8000, 1'b1, 1'b1);

        runOp(OP_SUB, 16'h0002, 16'h0005, 16'h2222, lat);
        checkOutput("sub", 16'hFFFD, 1'b1, 1'b0);

        runOp(OP_MUL, 16'h0007, 16'h3333, 16'h0006, lat);
        checkLatency("mul_latency", lat, 1 + ITERS);
        checkOutput("mul_7x6", 16'h002A, 1'b1, 1'b0);
        applyNoise(ST_WAIT);
        checkOutput("hold_wait", 16'h002A, 1'b1, 1'b0);
        applyNoise(ST_STORE);
        checkOutput("hold_store", 16'h002A, 1'b1, 1'b0);
        applyNoise(ST_FETCH);
        checkOutput("fetch_clears", 16'h002A, 1'b0, 1'b0);

        runOp(OP_MUL, 16'h0100, 16'h0000, 16'h0100, lat);
        checkLatency("mul_ovf_latency", lat, 1 + ITERS);
        checkOutput("mul_ovf", 16'h0000, 1'b1, 1'b1);

        // asynchronous reset at edge 8 of a MUL
        applyNoise(ST_FETCH);
        applyNoise(ST_READ);
        applyStimulus(ST_CALC, OP_MUL, 16'h0007, 16'h0000, 16'h0006);
        repeat (7) applyNoise(ST_WAIT);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_mul", 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // OFF in the middle of a MUL
        applyNoise(ST_FETCH);
        applyNoise(ST_READ);
        applyStimulus(ST_CALC, OP_MUL, 16'h1234, 16'h0000, 16'h0042);
        repeat (5) applyNoise(ST_WAIT);
        applyNoise(ST_OFF);
        checkOutput("off_abort", 16'h0000, 1'b0, 1'b0);
        repeat (ITERS) applyNoise(ST_WAIT);
        checkOutput("off_no_late_done", 16'h0000, 1'b0, 1'b0);
        runOp(OP_LOAD, 16'hAAAA, 16'h5555, 16'h1234, lat);
        checkLatency("load_latency", lat, 1);
        checkOutput("load_after_off", 16'h1234, 1'b1, 1'b0);

        runOp(OP_CLEAR, 16'h9999, 16'h8888, 16'h7777, lat);
        checkOutput("clear", 16'h0000, 1'b1, 1'b0);
        runOp(OP_DISPLAY, 16'hBEEF, 16'h0001, 16'h0002, lat);
        checkOutput("display", 16'hBEEF, 1'b1, 1'b0);
        applyStimulus(ST_CALC, OP_ADD, 16'h0001, 16'h0001, 16'h0001);
        checkOutput("calc_in_done", 16'hBEEF, 1'b1, 1'b0);
        repeat (3) applyStimulus(ST_CALC, OP_LOAD, 16'h0000, 16'h0000, 16'h5A5A);
        checkOutput("no_restart", 16'hBEEF, 1'b1, 1'b0);

        // FETCH while the multiplier is running
        applyNoise(ST_FETCH);
        applyNoise(ST_READ);
        applyStimulus(ST_CALC, OP_MUL, 16'h0003, 16'h0000, 16'h0003);
        repeat (3) applyNoise(ST_WAIT);
        applyNoise(ST_FETCH);
        repeat (ITERS + 2) applyNoise(ST_WAIT);
        checkOutput("fetch_abort_mul", 16'hBEEF, 1'b0, 1'b0);

        // randomized instruction stream with occasional aborts
        for (int k = 0; k < 60; k++) begin
            int abortAt;
            op = 3'($urandom_range(0, 7));
            applyNoise(ST_FETCH);
            applyNoise(ST_DECODE);
            applyNoise(ST_READ);
            applyStimulus(ST_CALC, op, pick(), pick(), pick());
            abortAt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 18)) : 0;
            for (int c = 1; c < 40 && !calcDone; c++) begin
                if (c == abortAt) begin
                    applyNoise(($urandom_range(0, 1) == 1) ? ST_OFF : ST_FETCH);
                    break;
                end
                applyNoise(ST_WAIT);
            end
            applyNoise(ST_STORE);
            if ($urandom_range(0, 1) == 1) applyNoise(ST_SHOW);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
